// File: rtl/wfq_flow_monitor.sv
// wfq_flow_monitor
//
// Per-flow service monitor for the WFQ scheduler output. Every dequeue request
// is delayed by RD_LATENCY cycles so that it lines up with the scheduler's
// output data. Each resulting sample is then counted against its flow, either
// as one packet or as length*8 bytes. Counts build up over a measurement
// window. When the window closes they are copied into snapshot registers,
// which are read through a one-cycle-latency stat port.
//
// Ports
//   clk               clock, rising edge
//   rst               synchronous reset, active-low
//   in_rd_packet_req  dequeue request pulse (same strobe the scheduler sees)
//   in_packet_data    scheduler output data; flow id in [FLOW_W-1:0]
//   in_packet_length  served packet length in 8-byte words
//   cfg_count_bytes   0: count packets, 1: count bytes
//   cfg_window_len    window length in cycles, 0: close only on in_snapshot
//   in_snapshot       force-close the current window
//   in_clear          zero live and snapshot state (wins over window close)
//   in_stat_rd_req    stat read strobe
//   in_stat_idx       flow index; NUM_FLOWS selects the unmatched counter
//   out_stat_valid    read data valid, one cycle after the strobe
//   out_stat_count    snapshot count for the requested index
//   out_stat_total    snapshot sum over all flows (unmatched excluded)
//   out_window_done   one-cycle pulse after a window closes
//   out_overflow      a live counter saturated in the last closed window
module wfq_flow_monitor #(
  parameter int NUM_FLOWS  = 4,
  parameter int DATA_W     = 64,
  parameter int FLOW_W     = 13,
  parameter int LEN_W      = 9,
  parameter int CNT_W      = 32,
  parameter int RD_LATENCY = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_rd_packet_req,
  input  logic [DATA_W-1:0]   in_packet_data,
  input  logic [LEN_W-1:0]    in_packet_length,
  input  logic                cfg_count_bytes,
  input  logic [31:0]         cfg_window_len,
  input  logic                in_snapshot,
  input  logic                in_clear,
  input  logic                in_stat_rd_req,
  input  logic [6:0]          in_stat_idx,
  output logic                out_stat_valid,
  output logic [CNT_W-1:0]    out_stat_count,
  output logic [CNT_W+5:0]    out_stat_total,
  output logic                out_window_done,
  output logic                out_overflow
);

  localparam int TOT_W = CNT_W + 6;
  localparam int INC_W = LEN_W + 3;
  // The adder is one bit wider than both operands, so a carry past 2^CNT_W-1
  // is always visible and can be detected.
  localparam int SUM_W = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;

  logic [RD_LATENCY-1:0] dl_q, dl_d;
  logic [CNT_W-1:0]      live_q [NUM_FLOWS];
  logic [CNT_W-1:0]      live_d [NUM_FLOWS];
  logic [CNT_W-1:0]      unm_q, unm_d;
  logic                  ovf_live_q, ovf_live_d;
  logic [CNT_W-1:0]      snap_q [NUM_FLOWS];
  logic [CNT_W-1:0]      snap_d [NUM_FLOWS];
  logic [CNT_W-1:0]      snap_unm_q, snap_unm_d;
  logic [TOT_W-1:0]      snap_total_q, snap_total_d;
  logic                  ovf_q, ovf_d;
  logic [31:0]           win_q, win_d;
  logic                  done_q, done_d;
  logic                  stat_valid_q, stat_valid_d;
  logic [CNT_W-1:0]      stat_count_q, stat_count_d;
  logic [TOT_W-1:0]      stat_total_q, stat_total_d;

  logic                  sample;
  logic [FLOW_W-1:0]     fid;
  logic [SUM_W-1:0]      inc;
  logic [CNT_W:0]        sum_r;
  logic [CNT_W-1:0]      acc [NUM_FLOWS];
  logic [CNT_W-1:0]      acc_unm;
  logic                  acc_ovf;
  logic                  close;
  logic [TOT_W-1:0]      tot;

  // Only the flow-id field of the data bus matters here.
  logic unused_data;
  assign unused_data = ^in_packet_data[DATA_W-1:FLOW_W];

  // Returns {saturated, clamped_sum}.
  function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] a,
                                             input logic [SUM_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + b;
    if (s > SUM_W'({CNT_W{1'b1}})) sat_add = {1'b1, {CNT_W{1'b1}}};
    else                           sat_add = {1'b0, s[CNT_W-1:0]};
  endfunction

  always_comb begin
    dl_d    = dl_q << 1;
    dl_d[0] = in_rd_packet_req;

    sample  = dl_q[RD_LATENCY-1];
    fid     = in_packet_data[FLOW_W-1:0];
    inc     = cfg_count_bytes ? SUM_W'({in_packet_length, 3'b000}) : SUM_W'(1);

    // Live counters after this cycle's sample, before any window action.
    sum_r   = '0;
    acc_unm = unm_q;
    acc_ovf = ovf_live_q;
    for (int i = 0; i < NUM_FLOWS; i++) acc[i] = live_q[i];
    if (sample) begin
      if (fid < FLOW_W'(NUM_FLOWS)) begin
        for (int i = 0; i < NUM_FLOWS; i++) begin
          if (fid == FLOW_W'(i)) begin
            sum_r   = sat_add(live_q[i], inc);
            acc[i]  = sum_r[CNT_W-1:0];
            acc_ovf = acc_ovf | sum_r[CNT_W];
          end
        end
      end else begin
        sum_r   = sat_add(unm_q, inc);
        acc_unm = sum_r[CNT_W-1:0];
        acc_ovf = acc_ovf | sum_r[CNT_W];
      end
    end

    close = in_snapshot ||
            ((cfg_window_len != 32'd0) && (win_q == cfg_window_len - 32'd1));

    tot = '0;
    for (int i = 0; i < NUM_FLOWS; i++) tot = tot + TOT_W'(acc[i]);

    for (int i = 0; i < NUM_FLOWS; i++) begin
      live_d[i] = acc[i];
      snap_d[i] = snap_q[i];
    end
    unm_d        = acc_unm;
    ovf_live_d   = acc_ovf;
    win_d        = win_q + 32'd1;
    snap_unm_d   = snap_unm_q;
    snap_total_d = snap_total_q;
    ovf_d        = ovf_q;
    done_d       = 1'b0;

    if (in_clear) begin
      // The coincident sample is dropped because acc is not used here.
      for (int i = 0; i < NUM_FLOWS; i++) begin
        live_d[i] = '0;
        snap_d[i] = '0;
      end
      unm_d        = '0;
      ovf_live_d   = 1'b0;
      win_d        = '0;
      snap_unm_d   = '0;
      snap_total_d = '0;
      ovf_d        = 1'b0;
    end else if (close) begin
      for (int i = 0; i < NUM_FLOWS; i++) begin
        snap_d[i] = acc[i];
        live_d[i] = '0;
      end
      snap_unm_d   = acc_unm;
      snap_total_d = tot;
      ovf_d        = acc_ovf;
      unm_d        = '0;
      ovf_live_d   = 1'b0;
      win_d        = '0;
      done_d       = 1'b1;
    end

    // Reads use the registered snapshot, so a read in a close cycle still
    // returns the previous window.
    stat_valid_d = in_stat_rd_req;
    stat_count_d = stat_count_q;
    stat_total_d = stat_total_q;
    if (in_stat_rd_req) begin
      stat_count_d = '0;
      stat_total_d = '0;
      for (int i = 0; i < NUM_FLOWS; i++) begin
        if (in_stat_idx == 7'(i)) begin
          stat_count_d = snap_q[i];
          stat_total_d = snap_total_q;
        end
      end
      if (in_stat_idx == 7'(NUM_FLOWS)) begin
        stat_count_d = snap_unm_q;
        stat_total_d = snap_total_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dl_q <= '0;
      for (int i = 0; i < NUM_FLOWS; i++) begin
        live_q[i] <= '0;
        snap_q[i] <= '0;
      end
      unm_q        <= '0;
      ovf_live_q   <= 1'b0;
      snap_unm_q   <= '0;
      snap_total_q <= '0;
      ovf_q        <= 1'b0;
      win_q        <= '0;
      done_q       <= 1'b0;
      stat_valid_q <= 1'b0;
      stat_count_q <= '0;
      stat_total_q <= '0;
    end else begin
      dl_q <= dl_d;
      for (int i = 0; i < NUM_FLOWS; i++) begin
        live_q[i] <= live_d[i];
        snap_q[i] <= snap_d[i];
      end
      unm_q        <= unm_d;
      ovf_live_q   <= ovf_live_d;
      snap_unm_q   <= snap_unm_d;
      snap_total_q <= snap_total_d;
      ovf_q        <= ovf_d;
      win_q        <= win_d;
      done_q       <= done_d;
      stat_valid_q <= stat_valid_d;
      stat_count_q <= stat_count_d;
      stat_total_q <= stat_total_d;
    end
  end

  assign out_stat_valid  = stat_valid_q;
  assign out_stat_count  = stat_count_q;
  assign out_stat_total  = stat_total_q;
  assign out_window_done = done_q;
  assign out_overflow    = ovf_q;

endmodule

// File: tb/tb_wfq_flow_monitor.sv
module tb_wfq_flow_monitor;
  localparam int LAT = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, cfg_bytes, snap, clr, rd, rd_s;
  logic [63:0] pdata;
  logic [8:0]  plen;
  logic [31:0] wlen;
  logic [6:0]  idx;
  logic [12:0] req_fid;
  logic [8:0]  req_len;

  logic        vld, done, ovf;
  logic [31:0] cnt;
  logic [37:0] tot;
  logic        vld_s, done_s, ovf_s;
  logic [3:0]  cnt_s;
  logic [9:0]  tot_s;

  wfq_flow_monitor #(.NUM_FLOWS(4), .CNT_W(32), .RD_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .in_rd_packet_req(req), .in_packet_data(pdata),
    .in_packet_length(plen), .cfg_count_bytes(cfg_bytes), .cfg_window_len(wlen),
    .in_snapshot(snap), .in_clear(clr), .in_stat_rd_req(rd), .in_stat_idx(idx),
    .out_stat_valid(vld), .out_stat_count(cnt), .out_stat_total(tot),
    .out_window_done(done), .out_overflow(ovf));

  wfq_flow_monitor #(.NUM_FLOWS(4), .CNT_W(4), .RD_LATENCY(LAT)) dut_s (
    .clk(clk), .rst(rst), .in_rd_packet_req(req), .in_packet_data(pdata),
    .in_packet_length(plen), .cfg_count_bytes(cfg_bytes), .cfg_window_len(wlen),
    .in_snapshot(snap), .in_clear(clr), .in_stat_rd_req(rd_s), .in_stat_idx(idx),
    .out_stat_valid(vld_s), .out_stat_count(cnt_s), .out_stat_total(tot_s),
    .out_window_done(done_s), .out_overflow(ovf_s));

  // Scheduler stand-in: presents each request's flow id and length RD_LATENCY
  // cycles later; idle cycles carry a misleading id/length.
  bit          p_v   [LAT];
  logic [12:0] p_fid [LAT];
  logic [8:0]  p_len [LAT];
  always @(posedge clk) begin
    p_v[0]   <= req;
    p_fid[0] <= req_fid;
    p_len[0] <= req_len;
    for (int i = 1; i < LAT; i++) begin
      p_v[i]   <= p_v[i-1];
      p_fid[i] <= p_fid[i-1];
      p_len[i] <= p_len[i-1];
    end
  end
  always_comb begin
    pdata = p_v[LAT-1] ? {51'h0_1234_5678_9ABC, p_fid[LAT-1]} : {51'h7_0000_0000_0000, 13'd2};
    plen  = p_v[LAT-1] ? p_len[LAT-1] : 9'd31;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  typedef struct { int idx; logic [37:0] c; logic [37:0] t; } exp_t;
  exp_t sb_q[$];
  exp_t sbs_q[$];
  exp_t e_m, e_s;

  always @(negedge clk) begin
    if (vld) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid count=%0d total=%0d", cnt, tot);
      end else begin
        e_m = sb_q.pop_front();
        check($sformatf("count[%0d]", e_m.idx), 64'(cnt), 64'(e_m.c));
        check($sformatf("total[%0d]", e_m.idx), 64'(tot), 64'(e_m.t));
      end
    end
  end

  always @(negedge clk) begin
    if (vld_s) begin
      if (sbs_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid_sat count=%0d total=%0d", cnt_s, tot_s);
      end else begin
        e_s = sbs_q.pop_front();
        check($sformatf("sat_count[%0d]", e_s.idx), 64'(cnt_s), 64'(e_s.c));
        check($sformatf("sat_total[%0d]", e_s.idx), 64'(tot_s), 64'(e_s.t));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Consecutive calls issue back-to-back reads.
  task automatic do_rd(input int i, input logic [37:0] c, input logic [37:0] t);
    exp_t x;
    x.idx = i; x.c = c; x.t = t;
    sb_q.push_back(x);
    rd = 1'b1; idx = 7'(i);
    tick();
    rd = 1'b0;
  endtask

  task automatic do_rd_s(input int i, input logic [37:0] c, input logic [37:0] t);
    exp_t x;
    x.idx = i; x.c = c; x.t = t;
    sbs_q.push_back(x);
    rd_s = 1'b1; idx = 7'(i);
    tick();
    rd_s = 1'b0;
  endtask

  task automatic pulse_snap();
    snap = 1'b1; tick(); snap = 1'b0; tick();
  endtask

  task automatic pulse_clear();
    clr = 1'b1; tick(); clr = 1'b0;
  endtask

  task automatic send(input int f, input int l);
    req = 1'b1; req_fid = 13'(f); req_len = 9'(l);
    tick();
    req = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int at);
    int n0;
    n0 = done_cnt;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cnt != n0) begin
        at = cyc;
        break;
      end
    end
    check("window_done_seen", 64'(at >= 0), 64'd1);
  endtask

  int a1, a2, a3, d0;

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req = 1'b0; req_fid = '0; req_len = '0; cfg_bytes = 1'b0;
    wlen = '0; snap = 1'b0; clr = 1'b0; rd = 1'b0; rd_s = 1'b0; idx = '0;
    repeat (3) tick();
    check("rst_valid", 64'(vld), 0);
    check("rst_count", 64'(cnt), 0);
    check("rst_total", 64'(tot), 0);
    check("rst_done", 64'(done), 0);
    check("rst_overflow", 64'(ovf), 0);
    rst = 1'b1;
    tick();

    // Round-robin packet mode: 40 back-to-back requests.
    for (int i = 0; i < 40; i++) begin
      req = 1'b1; req_fid = 13'(i % 4); req_len = 9'd1;
      tick();
    end
    req = 1'b0;
    repeat (LAT + 2) tick();
    pulse_snap();
    check("rr_done_pulses", 64'(done_cnt), 1);
    do_rd(0, 10, 40);
    do_rd(1, 10, 40);
    do_rd(2, 10, 40);
    do_rd(3, 10, 40);
    do_rd(4, 0, 40);
    do_rd(5, 0, 0);
    tick();

    // Byte mode, including an out-of-range id.
    cfg_bytes = 1'b1;
    pulse_clear();
    send(2, 5); send(2, 5); send(2, 5); send(9, 5);
    repeat (LAT + 2) tick();
    pulse_snap();
    do_rd(2, 120, 120);
    do_rd(4, 40, 120);
    do_rd(0, 0, 120);
    cfg_bytes = 1'b0;
    tick();

    // Auto window of 100 cycles with continuous traffic on flow 1.
    wlen = 32'd100;
    req = 1'b1; req_fid = 13'd1; req_len = 9'd0;
    pulse_clear();
    wait_done(150, a1);
    wait_done(150, a2);
    wait_done(150, a3);
    check("window_period_1", 64'(a2 - a1), 100);
    check("window_period_2", 64'(a3 - a2), 100);
    do_rd(1, 100, 100);
    do_rd(0, 0, 100);
    req = 1'b0;
    repeat (LAT + 3) tick();
    wlen = 32'd0;
    pulse_clear();
    tick();

    // Saturation on the 4-bit instance.
    pulse_clear();
    for (int i = 0; i < 20; i++) send(0, 1);
    repeat (LAT + 2) tick();
    pulse_snap();
    check("sat_overflow_set", 64'(ovf_s), 1);
    check("wide_overflow_clear", 64'(ovf), 0);
    do_rd_s(0, 15, 15);
    pulse_snap();
    check("sat_overflow_cleared", 64'(ovf_s), 0);
    do_rd_s(0, 0, 0);
    tick();

    // Sample coincident with window close lands in that snapshot.
    pulse_clear();
    send(3, 1);
    repeat (6) tick();
    snap = 1'b1; tick(); snap = 1'b0;
    tick();
    do_rd(3, 1, 1);
    pulse_snap();
    do_rd(3, 0, 0);

    // Sample coincident with clear is dropped.
    send(3, 1);
    repeat (6) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    repeat (LAT + 2) tick();
    pulse_snap();
    do_rd(3, 0, 0);

    // Requests in flight across a clear are counted afterwards; a read in
    // the close cycle returns the previous snapshot.
    send(3, 1); send(3, 1);
    pulse_clear();
    repeat (LAT + 3) tick();
    snap = 1'b1;
    do_rd(3, 0, 0);
    snap = 1'b0;
    do_rd(3, 2, 2);
    tick();

    // Reset with three requests in flight.
    send(0, 1); send(0, 1); send(0, 1);
    rst = 1'b0; tick(); rst = 1'b1;
    d0 = done_cnt;
    repeat (LAT + 8) tick();
    check("mid_rst_valid", 64'(vld), 0);
    check("mid_rst_count", 64'(cnt), 0);
    check("mid_rst_total", 64'(tot), 0);
    check("mid_rst_done", 64'(done), 0);
    check("mid_rst_overflow", 64'(ovf), 0);
    check("mid_rst_no_window", 64'(done_cnt), 64'(d0));
    do_rd(3, 0, 0);
    pulse_snap();
    do_rd(0, 0, 0);
    do_rd(4, 0, 0);

    repeat (5) tick();
    check("scoreboard_drained", 64'(sb_q.size()), 0);
    check("sat_scoreboard_drained", 64'(sbs_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
